// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: data-memory front end for a single-cycle datapath.
//
// Word stores are posted into a DEPTH-entry FIFO and complete with no wait. The FIFO drains
// in the background to a slower handshaked backing memory. A word load returns the youngest
// buffered store to the same word with no wait. Otherwise the load stalls while a read goes
// to backing memory. The buffer does not have to drain first: a miss means no buffered
// entry overlaps the load address.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous reset, active low
//   MemWrite    current instruction is a word store
//   MemRead     current instruction is a word load (ignored when MemWrite is also set)
//   ALUResult   byte address; addr[1:0] ignored
//   WriteData   store data
//   ReadData    load data (hit data, or last data returned from backing memory)
//   Stall       current memory instruction cannot complete this cycle
//   Empty       store buffer holds no entries
//   mem_req     backing-memory request valid
//   mem_we      1 = write (drain), 0 = read (load miss)
//   mem_addr    word-aligned request address
//   mem_wdata   write data
//   mem_ready   request accepted this cycle
//   mem_rvalid  read data valid (one or more cycles after read acceptance)
//   mem_rdata   read data
module dmem_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemWrite,
  input  logic          MemRead,
  input  logic [AW-1:0] ALUResult,
  input  logic [31:0]   WriteData,
  output logic [31:0]   ReadData,
  output logic          Stall,
  output logic          Empty,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned WAW = AW - 2;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StLoadReq,
    StLoadWait,
    StLoadDone
  } state_e;

  state_e         state_q;
  logic [WAW-1:0] addr_q [DEPTH];
  logic [31:0]    data_q [DEPTH];
  logic [PW-1:0]  head_q;
  logic [PW-1:0]  tail_q;
  logic [CW-1:0]  count_q;
  logic [31:0]    load_q;
  logic [WAW-1:0] ld_addr_q;

  logic [WAW-1:0] word_addr;
  logic           buf_empty;
  logic           buf_full;
  logic           hit;
  logic [31:0]    hit_data;
  logic [PW-1:0]  idx;
  logic           push;
  logic           pop;
  logic           load_miss;

  // Byte offset within the word is don't-care for word accesses.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^ALUResult[1:0];

  assign word_addr = ALUResult[AW-1:2];
  assign buf_empty = (count_q == '0);
  assign buf_full  = (count_q == FULL_COUNT);
  assign Empty     = buf_empty;

  // Forwarding search. Entries are visited oldest to youngest (age i from head), so the
  // last match found is the youngest store to that word.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx] == word_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  // Full is judged on the registered count, so a store never relies on a same-cycle pop.
  assign push      = (state_q == StIdle) && MemWrite && !buf_full;
  assign pop       = (state_q == StIdle) && !buf_empty && mem_ready;
  assign load_miss = (state_q == StIdle) && MemRead && !MemWrite && !hit;

  // Entry storage carries no reset; entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= word_addr;
      data_q[tail_q] <= WriteData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      state_q   <= StIdle;
      load_q    <= '0;
      ld_addr_q <= '0;
    end else begin
      if (push) begin
        tail_q <= tail_q + PW'(1);
      end
      if (pop) begin
        head_q <= head_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (load_miss) begin
            state_q   <= StLoadReq;
            ld_addr_q <= word_addr;
          end
        end
        StLoadReq: begin
          if (mem_ready) begin
            state_q <= StLoadWait;
          end
        end
        StLoadWait: begin
          if (mem_rvalid) begin
            load_q  <= mem_rdata;
            state_q <= StLoadDone;
          end
        end
        StLoadDone: begin
          // The datapath completes the load at this edge; drain resumes next cycle.
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Bus and datapath outputs decode directly from registered state. While a drain write
  // waits for mem_ready, head does not move, so the bus holds steady.
  always_comb begin
    Stall     = 1'b0;
    ReadData  = load_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      StIdle: begin
        if (!buf_empty) begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {addr_q[head_q], 2'b00};
          mem_wdata = data_q[head_q];
        end
        if (MemWrite) begin
          Stall = buf_full;
        end else if (MemRead) begin
          if (hit) begin
            ReadData = hit_data;
          end else begin
            Stall = 1'b1;
          end
        end
      end
      StLoadReq: begin
        Stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {ld_addr_q, 2'b00};
      end
      StLoadWait: begin
        Stall = 1'b1;
      end
      StLoadDone: begin
        ReadData = load_q;
      end
      default: begin
        Stall = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer: reset check, directed vector table, reset during
// a load, pointer wrap, and a randomized run against a queue-based architectural model.
module tb_dmem_store_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite, MemRead;
  logic [31:0] ALUResult, WriteData, ReadData;
  logic        Stall, Empty, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready, mem_rvalid;

  dmem_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Empty     (Empty),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Values sampled mid-cycle, before the rising edge.
  logic        s_stall, s_empty, s_req, s_we;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        rd_hs;
  logic [31:0] rd_hs_addr;
  logic [63:0] wlog[$];
  logic [31:0] bmem[logic [29:0]];
  logic [31:0] arch[logic [29:0]];

  typedef struct {
    logic        we, rd;
    logic [31:0] addr, wdata;
    logic        ready, rvalid;
    logic [31:0] rdata;
    logic        e_stall, e_empty, e_req, e_we;
    logic [31:0] e_addr, e_wdata;
    logic        c_rd;
    logic [31:0] e_rd;
  } vec_t;
  vec_t vecs[$];

  typedef struct {
    logic [29:0] w;
    logic [31:0] d;
  } ent_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [29:0] w);
    return 32'hC000_0000 ^ {2'b00, w};
  endfunction

  function automatic logic [31:0] bval(input logic [29:0] w);
    return bmem.exists(w) ? bmem[w] : dflt(w);
  endfunction

  function automatic logic [31:0] aval(input logic [29:0] w);
    return arch.exists(w) ? arch[w] : dflt(w);
  endfunction

  // Inputs are driven at the falling edge; sample 2 ns later, then go to the next falling edge.
  task automatic tick();
    #2;
    s_stall = Stall;
    s_empty = Empty;
    s_req   = mem_req;
    s_we    = mem_we;
    s_addr  = mem_addr;
    s_wdata = mem_wdata;
    s_rdata = ReadData;
    if (mem_req && mem_we && mem_ready) begin
      wlog.push_back({mem_addr, mem_wdata});
      bmem[mem_addr[31:2]] = mem_wdata;
    end
    rd_hs      = mem_req && !mem_we && mem_ready;
    rd_hs_addr = mem_addr;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    MemWrite   = 1'b0;
    MemRead    = 1'b0;
    ALUResult  = '0;
    WriteData  = '0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic add(input logic we, input logic rd, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic ready, input logic rvalid,
                     input logic [31:0] rdata, input logic e_stall, input logic e_empty,
                     input logic e_req, input logic e_we, input logic [31:0] e_addr,
                     input logic [31:0] e_wdata, input logic c_rd, input logic [31:0] e_rd);
    vec_t v;
    v = '{we, rd, addr, wdata, ready, rvalid, rdata, e_stall, e_empty, e_req, e_we, e_addr,
          e_wdata, c_rd, e_rd};
    vecs.push_back(v);
  endtask

  initial begin
    ent_t        mq[$];
    ent_t        ent;
    int          ph;
    logic [29:0] ldw, w;
    logic [31:0] ldv, rv_data, e_rd, e_addr;
    int          rv_cnt, op, guard;
    logic        hold, e_stall, e_req, e_we, hit;
    logic [31:0] hit_v;

    // ---- Reset values ----
    idle_inputs();
    reset = 1'b0;
    #1;
    chk("reset Stall", {31'b0, Stall}, 32'd0);
    chk("reset Empty", {31'b0, Empty}, 32'd1);
    chk("reset mem_req", {31'b0, mem_req}, 32'd0);
    chk("reset mem_we", {31'b0, mem_we}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset ReadData", ReadData, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // ---- Directed vector table ----
    //  we rd addr    wdata  rdy rv rdata      stl emp req mwe maddr   mwdata crd erd
    // Three stores with an always-ready memory.
    add(0, 0, 0,      0,     1, 0, 0,          0, 1, 0, 0, 0,      0,     1, 0);
    add(1, 0, 'h100,  'hA,   1, 0, 0,          0, 1, 0, 0, 0,      0,     0, 0);
    add(1, 0, 'h104,  'hB,   1, 0, 0,          0, 0, 1, 1, 'h100,  'hA,   0, 0);
    add(1, 0, 'h108,  'hC,   1, 0, 0,          0, 0, 1, 1, 'h104,  'hB,   0, 0);
    add(0, 0, 0,      0,     1, 0, 0,          0, 0, 1, 1, 'h108,  'hC,   0, 0);
    add(0, 0, 0,      0,     1, 0, 0,          0, 1, 0, 0, 0,      0,     0, 0);
    // Fill with memory not ready; fifth store stalls until a pop frees a slot.
    add(1, 0, 'h10,   1,     0, 0, 0,          0, 1, 0, 0, 0,      0,     0, 0);
    add(1, 0, 'h14,   2,     0, 0, 0,          0, 0, 1, 1, 'h10,   1,     0, 0);
    add(1, 0, 'h18,   3,     0, 0, 0,          0, 0, 1, 1, 'h10,   1,     0, 0);
    add(1, 0, 'h1C,   4,     0, 0, 0,          0, 0, 1, 1, 'h10,   1,     0, 0);
    add(1, 0, 'h20,   5,     0, 0, 0,          1, 0, 1, 1, 'h10,   1,     0, 0);
    add(1, 0, 'h20,   5,     1, 0, 0,          1, 0, 1, 1, 'h10,   1,     0, 0);
    add(1, 0, 'h20,   5,     0, 0, 0,          0, 0, 1, 1, 'h14,   2,     0, 0);
    add(0, 0, 0,      0,     1, 0, 0,          0, 0, 1, 1, 'h14,   2,     0, 0);
    add(0, 0, 0,      0,     1, 0, 0,          0, 0, 1, 1, 'h18,   3,     0, 0);
    add(0, 0, 0,      0,     1, 0, 0,          0, 0, 1, 1, 'h1C,   4,     0, 0);
    add(0, 0, 0,      0,     1, 0, 0,          0, 0, 1, 1, 'h20,   5,     0, 0);
    add(0, 0, 0,      0,     0, 0, 0,          0, 1, 0, 0, 0,      0,     0, 0);
    // Forwarding: youngest of two stores to the same word; no read issued.
    add(1, 0, 'h200,  'h11,  0, 0, 0,          0, 1, 0, 0, 0,      0,     0, 0);
    add(1, 0, 'h200,  'h22,  0, 0, 0,          0, 0, 1, 1, 'h200,  'h11,  0, 0);
    add(0, 1, 'h203,  0,     0, 0, 0,          0, 0, 1, 1, 'h200,  'h11,  1, 'h22);
    add(0, 0, 0,      0,     1, 0, 0,          0, 0, 1, 1, 'h200,  'h11,  0, 0);
    add(0, 0, 0,      0,     1, 0, 0,          0, 0, 1, 1, 'h200,  'h22,  0, 0);
    add(0, 0, 0,      0,     0, 0, 0,          0, 1, 0, 0, 0,      0,     0, 0);
    // Load miss bypasses a buffered store; data 3 cycles after acceptance.
    add(1, 0, 'h300,  'h33,  0, 0, 0,          0, 1, 0, 0, 0,      0,     0, 0);
    add(0, 1, 'h400,  0,     0, 0, 0,          1, 0, 1, 1, 'h300,  'h33,  0, 0);
    add(0, 1, 'h400,  0,     1, 0, 0,          1, 0, 1, 0, 'h400,  0,     0, 0);
    add(0, 1, 'h400,  0,     0, 0, 0,          1, 0, 0, 0, 0,      0,     0, 0);
    add(0, 1, 'h400,  0,     0, 0, 0,          1, 0, 0, 0, 0,      0,     0, 0);
    add(0, 1, 'h400,  0,     0, 1, 'hDEAD,     1, 0, 0, 0, 0,      0,     0, 0);
    add(0, 1, 'h400,  0,     0, 0, 0,          0, 0, 0, 0, 0,      0,     1, 'hDEAD);
    add(0, 0, 0,      0,     1, 0, 0,          0, 0, 1, 1, 'h300,  'h33,  1, 'hDEAD);
    add(0, 0, 0,      0,     0, 0, 0,          0, 1, 0, 0, 0,      0,     1, 'hDEAD);

    foreach (vecs[i]) begin
      MemWrite   = vecs[i].we;
      MemRead    = vecs[i].rd;
      ALUResult  = vecs[i].addr;
      WriteData  = vecs[i].wdata;
      mem_ready  = vecs[i].ready;
      mem_rvalid = vecs[i].rvalid;
      mem_rdata  = vecs[i].rdata;
      tick();
      chk($sformatf("row%0d Stall", i), {31'b0, s_stall}, {31'b0, vecs[i].e_stall});
      chk($sformatf("row%0d Empty", i), {31'b0, s_empty}, {31'b0, vecs[i].e_empty});
      chk($sformatf("row%0d mem_req", i), {31'b0, s_req}, {31'b0, vecs[i].e_req});
      if (vecs[i].e_req) begin
        chk($sformatf("row%0d mem_we", i), {31'b0, s_we}, {31'b0, vecs[i].e_we});
        chk($sformatf("row%0d mem_addr", i), s_addr, vecs[i].e_addr);
        if (vecs[i].e_we) chk($sformatf("row%0d mem_wdata", i), s_wdata, vecs[i].e_wdata);
      end
      if (vecs[i].c_rd) chk($sformatf("row%0d ReadData", i), s_rdata, vecs[i].e_rd);
    end

    // ---- Reset while waiting for read data, two stores buffered ----
    idle_inputs();
    MemWrite = 1'b1; ALUResult = 'h700; WriteData = 1; tick();
    ALUResult = 'h704; WriteData = 2; tick();
    MemWrite = 1'b0; MemRead = 1'b1; ALUResult = 'h800; tick();
    mem_ready = 1'b1; tick();
    mem_ready = 1'b0; tick();
    chk("rst-mid wait Stall", {31'b0, s_stall}, 32'd1);
    chk("rst-mid wait mem_req", {31'b0, s_req}, 32'd0);
    reset = 1'b0;
    MemRead = 1'b0;
    #1;
    chk("rst-mid Empty", {31'b0, Empty}, 32'd1);
    chk("rst-mid Stall", {31'b0, Stall}, 32'd0);
    chk("rst-mid mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst-mid ReadData", ReadData, 32'd0);
    tick();
    reset = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 'hBAD;
    tick();
    chk("late rvalid Stall", {31'b0, s_stall}, 32'd0);
    chk("late rvalid mem_req", {31'b0, s_req}, 32'd0);
    mem_rvalid = 1'b0;
    tick();
    chk("late rvalid ReadData", s_rdata, 32'd0);
    chk("late rvalid Empty", {31'b0, s_empty}, 32'd1);

    // ---- Pointer wrap: 10 stores with random readiness, then full drain ----
    do_reset();
    wlog.delete();
    for (int k = 0; k < 10; k++) begin
      MemWrite  = 1'b1;
      ALUResult = 32'h600 + 32'(4 * k);
      WriteData = 32'h1000 + 32'(k);
      guard = 0;
      do begin
        mem_ready = 1'($urandom_range(0, 1));
        tick();
        guard++;
      end while (s_stall && guard < 50);
      if (s_stall) chk($sformatf("wrap store%0d accepted", k), 32'd1, 32'd0);
    end
    MemWrite = 1'b0;
    guard = 0;
    do begin
      mem_ready = 1'($urandom_range(0, 1));
      tick();
      guard++;
    end while (!s_empty && guard < 200);
    chk("wrap drained", {31'b0, s_empty}, 32'd1);
    chk("wrap write count", 32'(wlog.size()), 32'd10);
    for (int k = 0; k < 10 && k < wlog.size(); k++) begin
      chk($sformatf("wrap write%0d addr", k), wlog[k][63:32], 32'h600 + 32'(4 * k));
      chk($sformatf("wrap write%0d data", k), wlog[k][31:0], 32'h1000 + 32'(k));
    end

    // ---- Randomized run against an architectural model ----
    do_reset();
    bmem.delete();
    arch.delete();
    mq.delete();
    ph = 0; ldw = '0; ldv = '0; rv_cnt = 0; rv_data = '0; hold = 1'b0; op = 0;
    for (int c = 0; c < 1200; c++) begin
      if (!hold) begin
        op        = $urandom_range(0, 2);
        MemWrite  = (op == 1);
        MemRead   = (op == 2);
        ALUResult = {30'h10 + 30'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
        WriteData = $urandom;
      end
      mem_ready  = ($urandom_range(0, 3) < 1 + (c / 100) % 3);
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rv_data;
        end
      end

      // Expected outputs from the model state and this cycle's inputs.
      w = ALUResult[31:2];
      hit = 1'b0; hit_v = '0;
      foreach (mq[i]) if (mq[i].w == w) begin hit = 1'b1; hit_v = mq[i].d; end
      e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_rd = ldv;
      case (ph)
        0: begin
          e_req = (mq.size() != 0);
          e_we  = e_req;
          if (e_req) e_addr = {mq[0].w, 2'b00};
          if (MemWrite) e_stall = (mq.size() == DEPTH);
          else if (MemRead) begin
            if (hit) e_rd = hit_v;
            else e_stall = 1'b1;
          end
        end
        1: begin e_stall = 1'b1; e_req = 1'b1; e_addr = {ldw, 2'b00}; end
        2: e_stall = 1'b1;
        default: e_rd = aval(ldw);
      endcase

      tick();
      if (rd_hs) begin
        rv_cnt  = $urandom_range(1, 3);
        rv_data = bval(rd_hs_addr[31:2]);
      end

      chk($sformatf("rnd%0d Stall", c), {31'b0, s_stall}, {31'b0, e_stall});
      chk($sformatf("rnd%0d Empty", c), {31'b0, s_empty}, {31'b0, (mq.size() == 0)});
      chk($sformatf("rnd%0d mem_req", c), {31'b0, s_req}, {31'b0, e_req});
      if (e_req) begin
        chk($sformatf("rnd%0d mem_we", c), {31'b0, s_we}, {31'b0, e_we});
        chk($sformatf("rnd%0d mem_addr", c), s_addr, e_addr);
        if (e_we) chk($sformatf("rnd%0d mem_wdata", c), s_wdata, mq[0].d);
      end
      chk($sformatf("rnd%0d ReadData", c), s_rdata, e_rd);

      // Model update.
      case (ph)
        0: begin
          logic do_push;
          do_push = MemWrite && (mq.size() < DEPTH);
          if (e_req && mem_ready) void'(mq.pop_front());
          if (do_push) begin
            ent.w = w;
            ent.d = WriteData;
            mq.push_back(ent);
            arch[w] = WriteData;
          end
          if (MemRead && !MemWrite && !hit) begin ph = 1; ldw = w; end
        end
        1: if (mem_ready) ph = 2;
        2: if (mem_rvalid) ph = 3;
        default: begin ldv = aval(ldw); ph = 0; end
      endcase
      hold = e_stall;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
